// File: rtl/div_pkg.sv
// Shared definitions for the iterative integer divider: width, op codes,
// FSM state encoding and a conditional two's-complement helper.
package div_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and emit one quotient bit.
module div_step #(
    parameter int unsigned XLEN = div_pkg::XLEN
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in XLEN+1 bits and bit XLEN of the difference is the borrow.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (trial[XLEN]) begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o = trial[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: captures operands on start, runs 32
// restoring steps, then writes the result back for exactly one cycle.
module div_unit #(
    parameter int unsigned XLEN = div_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic            regWrite,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3
);

    import div_pkg::*;

    state_e          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wr_q, wr_d;
    logic [4:0]      a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;

    logic [XLEN-1:0] rem_nx, quo_nx;
    logic            in_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] final_res;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (rem_nx),
        .quo_o     (quo_nx)
    );

    // Operand decode for the request presented at the IDLE edge.
    always_comb begin
        in_signed = (op == OP_DIV) || (op == OP_REM);
        a_neg     = in_signed & rs1_val[XLEN-1];
        b_neg     = in_signed & rs2_val[XLEN-1];
        a_abs     = cond_neg(a_neg, rs1_val);
        b_abs     = cond_neg(b_neg, rs2_val);
        div_zero  = (rs2_val == '0);
        ovf       = in_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        if (div_zero) begin
            special_res = op[1] ? rs1_val : '1;
        end else begin
            special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Result of the final step, with signs restored.
    always_comb begin
        if (op_q == OP_REM || op_q == OP_REMU) begin
            final_res = cond_neg(negr_q, rem_nx);
        end else begin
            final_res = cond_neg(negq_q, quo_nx);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wr_d    = 1'b0;
        a3_d    = '0;
        wd3_d   = '0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    op_d   = op;
                    rd_d   = rd_addr;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    rem_d  = '0;
                    quo_d  = a_abs;
                    dvsr_d = b_abs;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (div_zero || ovf) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        wr_d    = (rd_addr != 5'd0);
                        a3_d    = rd_addr;
                        wd3_d   = special_res;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(XLEN - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    wr_d    = (rd_q != 5'd0);
                    a3_d    = rd_q;
                    wd3_d   = final_res;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign regWrite = wr_q;
    assign a3       = a3_q;
    assign wd3      = wd3_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: timing, signed/unsigned results,
// divide-by-zero and overflow shortcuts, x0 suppression, reset and start rules.
module tb_div_unit;

    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic        regWrite;
    logic [4:0]  a3;
    logic [31:0] wd3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [18] = '{
        '{OP_REM,  32'd100,        32'd7,          32'd2,          32},
        '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32},
        '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32},
        '{OP_DIVU, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32},
        '{OP_REMU, 32'hFFFF_FFF9,  32'd2,          32'd1,          32},
        '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32},
        '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          32},
        '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32},
        '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32},
        '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32},
        '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32},
        '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32},
        '{OP_DIVU, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  0},
        '{OP_REMU, 32'h0000_1234,  32'd0,          32'h0000_1234,  0},
        '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0},
        '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0},
        '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  0},
        '{OP_REM,  32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0,  0}
    };

    always #5 clk = ~clk;

    div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .done     (done),
        .regWrite (regWrite),
        .a3       (a3),
        .wd3      (wd3)
    );

    // Present a request so that the next rising edge (edge 0) samples it, then
    // scramble the inputs to expose any use of uncaptured operands.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_addr = rd;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1; rd_addr = ~rd;
    endtask

    // Count edges after edge 0 until done is seen; max+1 means it never came.
    task automatic wait_done(input int max, output int n);
        n = 0;
        while (done !== 1'b1 && n <= max) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op = OP_DIV; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 5'd5;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b expected 0", regWrite); end
        checks++; if (a3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d expected 0", a3); end
        checks++; if (wd3 !== 32'd0) begin errors++; $display("FAIL reset_wd3: got %h expected 0", wd3); end
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after: got %b expected 0", busy); end
    endtask

    task automatic test_div_basic();
        issue(OP_DIV, 32'd100, 32'd7, 5'd5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL calc_busy: got %b expected 1", busy); end
        checks++; if (done !== 1'b0 || regWrite !== 1'b0 || wd3 !== 32'd0) begin
            errors++; $display("FAIL calc_outputs: done %b regWrite %b wd3 %h expected 0 0 0", done, regWrite, wd3);
        end
        repeat (31) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL edge31_done: got %b expected 0", done); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL edge32_done: got %b expected 1", done); end
        checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL edge32_regwrite: got %b expected 1", regWrite); end
        checks++; if (a3 !== 5'd5) begin errors++; $display("FAIL edge32_a3: got %0d expected 5", a3); end
        checks++; if (wd3 !== 32'd14) begin errors++; $display("FAIL edge32_wd3: got %h expected 0000000e", wd3); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || regWrite !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL edge33_ctrl: done %b regWrite %b busy %b expected 0 0 0", done, regWrite, busy);
        end
        checks++; if (wd3 !== 32'd0 || a3 !== 5'd0) begin
            errors++; $display("FAIL edge33_data: wd3 %h a3 %0d expected 0 0", wd3, a3);
        end
    endtask

    task automatic test_arith();
        int n;
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1));
            wait_done(40, n);
            checks++; if (n !== vecs[i].lat) begin errors++; $display("FAIL arith%0d_latency: got %0d expected %0d", i, n, vecs[i].lat); end
            checks++; if (wd3 !== vecs[i].exp) begin errors++; $display("FAIL arith%0d_wd3: got %h expected %h", i, wd3, vecs[i].exp); end
            checks++; if (regWrite !== 1'b1 || a3 !== 5'(i + 1)) begin
                errors++; $display("FAIL arith%0d_wb: regWrite %b a3 %0d expected 1 %0d", i, regWrite, a3, i + 1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_special();
        int n;
        for (int i = 12; i < 18; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1));
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL special%0d_busy: got %b expected 1", i, busy); end
            wait_done(40, n);
            checks++; if (n !== vecs[i].lat) begin errors++; $display("FAIL special%0d_latency: got %0d expected %0d", i, n, vecs[i].lat); end
            checks++; if (wd3 !== vecs[i].exp) begin errors++; $display("FAIL special%0d_wd3: got %h expected %h", i, wd3, vecs[i].exp); end
            checks++; if (regWrite !== 1'b1 || a3 !== 5'(i + 1)) begin
                errors++; $display("FAIL special%0d_wb: regWrite %b a3 %0d expected 1 %0d", i, regWrite, a3, i + 1);
            end
            @(posedge clk);
            #1;
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL special%0d_return: busy %b done %b expected 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_rd0();
        int n;
        issue(OP_DIV, 32'd9, 32'd3, 5'd0);
        wait_done(40, n);
        checks++; if (n !== 32) begin errors++; $display("FAIL rd0_latency: got %0d expected 32", n); end
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL rd0_regwrite: got %b expected 0", regWrite); end
        checks++; if (wd3 !== 32'd3 || a3 !== 5'd0) begin
            errors++; $display("FAIL rd0_data: wd3 %h a3 %0d expected 00000003 0", wd3, a3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_start();
        int n;
        issue(OP_DIV, 32'd100, 32'd7, 5'd5);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = OP_REMU; rs1_val = 32'd55; rs2_val = 32'd4; rd_addr = 5'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40, n);
        checks++; if (n + 5 !== 32) begin errors++; $display("FAIL ignore_latency: got %0d expected 32", n + 5); end
        checks++; if (wd3 !== 32'd14 || a3 !== 5'd5 || regWrite !== 1'b1) begin
            errors++; $display("FAIL ignore_result: wd3 %h a3 %0d regWrite %b expected 0000000e 5 1", wd3, a3, regWrite);
        end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_DIV, 32'd100, 32'd7, 5'd5);
        wait_done(40, n);
        checks++; if (n !== 32 || wd3 !== 32'd14) begin
            errors++; $display("FAIL b2b_first: latency %0d wd3 %h expected 32 0000000e", n, wd3);
        end
        start = 1'b1; op = OP_DIVU; rs1_val = 32'd20; rs2_val = 32'd3; rd_addr = 5'd7;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_done_edge: busy %b done %b expected 0 0", busy, done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
        wait_done(40, n);
        checks++; if (n !== 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", n); end
        checks++; if (wd3 !== 32'd6 || a3 !== 5'd7 || regWrite !== 1'b1) begin
            errors++; $display("FAIL b2b_result: wd3 %h a3 %0d regWrite %b expected 00000006 7 1", wd3, a3, regWrite);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int bad;
        issue(OP_DIV, 32'd100, 32'd7, 5'd5);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0 || regWrite !== 1'b0 || wd3 !== 32'd0 || a3 !== 5'd0) begin
            errors++; $display("FAIL abort_outputs: done %b regWrite %b wd3 %h a3 %0d expected all 0", done, regWrite, wd3, a3);
        end
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || regWrite !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_arith();
        test_special();
        test_rd0();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 rs1_val  input  XLEN  dividend (register file rd1).
REQ-007 rs2_val  input  XLEN  divisor (register file rd2).
REQ-008 rd_addr  input  5  destination register index.
REQ-009 busy  output  1  high while a request is in flight (not IDLE).
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 regWrite  output  1  write enable to the register file write port.
REQ-012 a3  output  5  write address to the register file.
REQ-013 wd3  output  XLEN  write data to the register file.

Function
REQ-014 FSM states IDLE, CALC, DONE; edge 0 is the rising edge that samples start=1 in IDLE.
REQ-015 At edge 0: op, rd_addr, |rs1_val|, |rs2_val| (unsigned for DIVU/REMU) and the result signs are captured; inputs are ignored from then until the unit returns to IDLE.
REQ-016 Normal path: at edge 0 go to CALC with a 6-bit counter at 0; run one restoring shift-subtract step per cycle for 32 cycles (edges 1..32); at edge 32 go to DONE.
REQ-017 DONE lasts exactly one cycle (between edges 32 and 33): done=1, wd3=result, a3=captured rd_addr, regWrite=1 unless rd_addr==0; at edge 33 go to IDLE.
REQ-018 Signed DIV: quotient negated when the operand signs differ; REM: remainder takes the dividend sign; truncation toward zero.
REQ-019 Divide by zero (rs2_val==0): skip CALC; at edge 0 go directly to DONE; quotient 0xFFFFFFFF (DIV and DIVU), remainder = rs1_val.
REQ-020 Signed overflow (DIV/REM, rs1_val==0x80000000, rs2_val==0xFFFFFFFF): skip CALC; at edge 0 go directly to DONE; quotient 0x80000000, remainder 0.
REQ-021 rd_addr==0: full computation still runs and done pulses, but regWrite stays 0 (x0 is never written).
REQ-022 start while busy=1 is ignored (no queueing); start in the IDLE cycle immediately after DONE is accepted.
REQ-023 Outside DONE: regWrite=0, done=0, wd3=0, a3=0.
REQ-024 busy=1 in CALC and DONE, 0 in IDLE.

Reset
REQ-025 rst=1 at any edge forces IDLE, counter 0, all datapath registers 0; busy=0, done=0, regWrite=0, a3=0, wd3=0 after that edge.
REQ-026 Reset mid-CALC aborts the operation; no regWrite or done for the aborted request ever appears.
REQ-027 rst has priority over start on the same edge.

Structure
REQ-028 Shared package div_pkg holds XLEN, the op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU) and the state encoding.
REQ-029 One combinational sub-module div_step (one restoring step: shift, trial subtract, quotient bit) is instantiated once; the FSM, counter and sign handling stay in div_unit.

Verification
REQ-030 DIV 100/7, rd_addr=5 -> regWrite=1, a3=5, wd3=14 exactly in the cycle between edges 32 and 33; REM 100/7 -> wd3=2.
REQ-031 DIV 0xFFFFFFF9 (-7)/2 -> wd3=0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
REQ-032 DIVU 0x1234/0 -> wd3=0xFFFFFFFF, REMU 0x1234/0 -> wd3=0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each with done in the cycle right after edge 0.
REQ-033 rst=1 at edge 10 of a DIV -> busy=0 after edge 10; no done/regWrite for the next 40 cycles.
REQ-034 Second start at edge 5 with different operands -> ignored, first result written unchanged; DIV 9/3 with rd_addr=0 -> done=1, regWrite=0.
